lsu_mem_initiator: RTL and testbench

//  Initiator side of the single-cycle synchronous data-memory port. Sits between the core's

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_mem_initiator.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory initiator: funct3 encodings,
// access-size decode and the FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WAIT = 3'd1,
    S_LD_HI   = 3'd2,
    S_ST_HI   = 3'd3,
    S_DONE    = 3'd4
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; codes 3/6/7 are rejected elsewhere.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    if (load) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
    end
    return (f3 < 3'd3);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data/mask placement across two words
// and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word_lo,
  input  logic [31:0] i_word_hi,
  output logic [31:0] o_lane_lo,
  output logic [31:0] o_lane_hi,
  output logic [3:0]  o_mask_lo,
  output logic [3:0]  o_mask_hi,
  output logic        o_cross,
  output logic [31:0] o_rdata
);

  logic [2:0]  w_size;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_m8;
  logic [5:0]  w_bit_off;
  logic [63:0] w_lanes;
  logic [63:0] w_shift;

  always_comb begin
    w_size      = size_bytes(i_funct3);
    w_size_mask = (w_size == 3'd1) ? 8'h01 : (w_size == 3'd2) ? 8'h03 : 8'h0F;
    w_bit_off   = {1'b0, i_off, 3'b000};
    w_m8        = w_size_mask << i_off;
    w_lanes     = {32'd0, i_wdata} << w_bit_off;
    w_shift     = {i_word_hi, i_word_lo} >> w_bit_off;
    o_cross     = ({2'b00, i_off} + {1'b0, w_size}) > 4'd4;
    o_lane_lo   = w_lanes[31:0];
    o_lane_hi   = w_lanes[63:32];
    o_mask_lo   = w_m8[3:0];
    o_mask_hi   = w_m8[7:4];
    o_rdata     = 32'd0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_rdata = w_shift[31:0];
      F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a single-cycle synchronous data memory port.
// Turns byte/half/word requests into masked word accesses, splitting word-crossing ones.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // Request handshake: a request transfers in a cycle where req_valid and
  // req_ready are both 1; req_ready is 1 only in IDLE. resp_valid is a
  // one-cycle completion pulse with no back-pressure.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data,
  output logic [2:0]  dbg_state
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [2:0]  r_funct3;
  logic        r_load;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic [31:0] r_lo;
  logic        r_err;
  logic [31:0] r_last;

  logic        w_idle;
  logic        w_accept;
  logic        w_req_illegal;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [31:0] w_wd;
  logic [31:0] w_word_lo;
  logic [31:0] w_addr_a;
  logic [31:0] w_addr_b;
  logic [31:0] w_lane_lo;
  logic [31:0] w_lane_hi;
  logic [3:0]  w_mask_lo;
  logic [3:0]  w_mask_hi;
  logic        w_cross;
  logic [31:0] w_rdata;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle && req_valid;
  assign req_ready = w_idle;
  assign dbg_state = r_state;

  // The aligner sees the live request in IDLE and the latched one afterwards.
  assign w_f3      = w_idle ? req_funct3 : r_funct3;
  assign w_off     = w_idle ? req_addr[1:0] : r_off;
  assign w_wd      = w_idle ? req_wdata : r_wdata;
  assign w_word_lo = (r_state == S_LD_HI) ? r_lo : mem_data;
  assign w_addr_a  = w_idle ? {req_addr[31:2], 2'b00} : r_addr;
  assign w_addr_b  = r_addr + 32'd4;

  assign w_req_illegal = !f3_legal(req_load, req_funct3) ||
                         (w_cross && (ALLOW_MISALIGNED == 1'b0));

  lsu_align u_align (
    .i_funct3  (w_f3),
    .i_off     (w_off),
    .i_wdata   (w_wd),
    .i_word_lo (w_word_lo),
    .i_word_hi (mem_data),
    .o_lane_lo (w_lane_lo),
    .o_lane_hi (w_lane_hi),
    .o_mask_lo (w_mask_lo),
    .o_mask_hi (w_mask_hi),
    .o_cross   (w_cross),
    .o_rdata   (w_rdata)
  );

  always_comb begin
    w_next     = r_state;
    mem_addr   = w_addr_a;
    mem_wmask  = 4'd0;
    mem_wdata  = w_lane_lo;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = r_last;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_illegal) begin
            w_next = S_DONE;
          end else if (req_load) begin
            w_next = S_LD_WAIT;
          end else begin
            mem_wmask = w_mask_lo;
            w_next    = w_cross ? S_ST_HI : S_DONE;
          end
        end
      end
      S_LD_WAIT: begin
        if (w_cross) begin
          mem_addr = w_addr_b;
          w_next   = S_LD_HI;
        end else begin
          resp_valid = 1'b1;
          resp_rdata = w_rdata;
          w_next     = S_IDLE;
        end
      end
      S_LD_HI: begin
        resp_valid = 1'b1;
        resp_rdata = w_rdata;
        w_next     = S_IDLE;
      end
      S_ST_HI: begin
        mem_addr  = w_addr_b;
        mem_wmask = w_mask_hi;
        mem_wdata = w_lane_hi;
        w_next    = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = 32'd0;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Suppress any write or response at the reset edge, including a pending beat1.
    if (reset) begin
      mem_wmask  = 4'd0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_load   <= 1'b0;
      r_off    <= 2'd0;
      r_wdata  <= 32'd0;
      r_addr   <= 32'd0;
      r_lo     <= 32'd0;
      r_err    <= 1'b0;
      r_last   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_load   <= req_load;
        r_off    <= req_addr[1:0];
        r_wdata  <= req_wdata;
        r_addr   <= {req_addr[31:2], 2'b00};
        r_err    <= w_req_illegal;
      end
      if (r_state == S_LD_WAIT) begin
        r_lo <= mem_data;
      end
      if (resp_valid) begin
        r_last <= resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed + randomized bench for lsu_mem_initiator with a word memory model
// and an expected-response queue.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        tb_clear;

  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [3:0]  mem_wmask;
  logic [2:0]  dbg_state;

  logic        nm_req_valid, nm_req_ready, nm_req_load;
  logic [2:0]  nm_req_funct3;
  logic [31:0] nm_req_addr, nm_req_wdata;
  logic        nm_resp_valid, nm_resp_err;
  logic [31:0] nm_resp_rdata;
  logic [31:0] nm_mem_addr, nm_mem_wdata, nm_mem_data;
  logic [3:0]  nm_mem_wmask;
  logic [2:0]  nm_dbg_state;

  logic [32:0] exp_q[$];
  int          checks;
  int          errors;

  logic [31:0] acc_addr, acc_data, nx_addr, nx_data;
  logic [3:0]  acc_mask, nx_mask;
  logic [31:0] mem [0:255];

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .dbg_state(dbg_state)
  );

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .reset(reset),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_load(nm_req_load),
    .req_funct3(nm_req_funct3), .req_addr(nm_req_addr), .req_wdata(nm_req_wdata),
    .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err),
    .mem_addr(nm_mem_addr), .mem_wmask(nm_mem_wmask), .mem_wdata(nm_mem_wdata),
    .mem_data(nm_mem_data), .dbg_state(nm_dbg_state)
  );

  assign nm_mem_data = 32'd0;

  // Clock and synchronous memory: old word returned on read-during-write.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem_data <= 32'd0;
    end else begin
      mem_data <= mem[mem_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (mem_wmask[k]) mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request to the main DUT, record the memory port in the accept
  // cycle and the following cycle, then score the response.
  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    logic [32:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    exp_q.push_back({exp_err, exp_rd});
    #1;
    chk("ready_at_accept", 64'(req_ready), 64'd1);
    acc_addr = mem_addr; acc_mask = mem_wmask; acc_data = mem_wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        nx_addr = mem_addr; nx_mask = mem_wmask; nx_data = mem_wdata;
      end
    end while (!resp_valid && lat < 8);
    chk("latency", 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    chk("resp", 64'({resp_err, resp_rdata}), 64'(e));
  endtask

  task automatic nm_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [3:0] exp_m0);
    int lat;
    @(negedge clk);
    nm_req_valid = 1'b1; nm_req_load = 1'b0; nm_req_funct3 = f3;
    nm_req_addr = a; nm_req_wdata = wd;
    #1;
    chk("nm_ready", 64'(nm_req_ready), 64'd1);
    chk("nm_mask0", 64'(nm_mem_wmask), 64'(exp_m0));
    @(posedge clk);
    #1 nm_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("nm_no_beat1", 64'(nm_mem_wmask), 64'd0);
    end while (!nm_resp_valid && lat < 8);
    chk("nm_latency", 64'(lat), 64'd1);
    chk("nm_resp", 64'({nm_resp_err, nm_resp_rdata}), 64'({exp_err, 32'd0}));
  endtask

  initial begin
    int w, o;
    logic [31:0] d;
    checks = 0; errors = 0;
    reset = 1'b1; tb_clear = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    nm_req_valid = 1'b0; nm_req_load = 1'b0; nm_req_funct3 = 3'd0;
    nm_req_addr = 32'd0; nm_req_wdata = 32'd0;

    // Reset: a store presented during reset must not write.
    repeat (2) @(negedge clk);
    tb_clear = 1'b0;
    req_valid = 1'b1; req_load = 1'b0; req_funct3 = F3_W;
    req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
    #1 chk("wmask_in_reset", 64'(mem_wmask), 64'd0);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    chk("idle_wmask", 64'(mem_wmask), 64'd0);
    chk("idle_addr_track", 64'(mem_addr), 64'h40);
    issue(1'b1, F3_W, 32'h40, 32'd0, 1'b0, 32'd0, 1);

    // Aligned word store then load.
    issue(1'b0, F3_W, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'd0, 1);
    chk("sw_mask", 64'(acc_mask), 64'hF);
    chk("sw_addr", 64'(acc_addr), 64'h100);
    chk("sw_data", 64'(acc_data), 64'hDEAD_BEEF);
    issue(1'b1, F3_W, 32'h100, 32'd0, 1'b0, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    chk("rdata_hold", 64'({resp_valid, resp_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));

    // Sub-word loads with sign/zero extension.
    issue(1'b0, F3_W, 32'h100, 32'h80FF_0000, 1'b0, 32'd0, 1);
    issue(1'b1, F3_B,  32'h103, 32'd0, 1'b0, 32'hFFFF_FF80, 1);
    issue(1'b1, F3_BU, 32'h103, 32'd0, 1'b0, 32'h0000_0080, 1);
    issue(1'b1, F3_H,  32'h102, 32'd0, 1'b0, 32'hFFFF_80FF, 1);
    issue(1'b1, F3_HU, 32'h102, 32'd0, 1'b0, 32'h0000_80FF, 1);

    // Misalignment rejected only when the access crosses a word.
    nm_issue(F3_H, 32'h207, 32'h0000_A1B2, 1'b1, 4'b0000);
    nm_issue(F3_H, 32'h206, 32'h0000_A1B2, 1'b0, 4'b1100);

    // Split halfword store.
    issue(1'b0, F3_H, 32'h207, 32'h0000_A1B2, 1'b0, 32'd0, 2);
    chk("split_st_addr0", 64'(acc_addr), 64'h204);
    chk("split_st_mask0", 64'(acc_mask), 64'b1000);
    chk("split_st_data0", 64'(acc_data), 64'hB200_0000);
    chk("split_st_addr1", 64'(nx_addr), 64'h208);
    chk("split_st_mask1", 64'(nx_mask), 64'b0001);
    chk("split_st_data1", 64'(nx_data), 64'h0000_00A1);
    issue(1'b1, F3_W, 32'h204, 32'd0, 1'b0, 32'hB200_0000, 1);
    issue(1'b1, F3_W, 32'h208, 32'd0, 1'b0, 32'h0000_00A1, 1);

    // Split loads.
    issue(1'b0, F3_W, 32'h1FC, 32'h3322_1100, 1'b0, 32'd0, 1);
    issue(1'b0, F3_W, 32'h200, 32'h7766_5544, 1'b0, 32'd0, 1);
    issue(1'b1, F3_W, 32'h1FE, 32'd0, 1'b0, 32'h5544_3322, 2);
    chk("split_ld_addr0", 64'(acc_addr), 64'h1FC);
    chk("split_ld_addr1", 64'(nx_addr), 64'h200);
    chk("split_ld_nowrite", 64'({acc_mask, nx_mask}), 64'd0);
    issue(1'b1, F3_H, 32'h1FF, 32'd0, 1'b0, 32'h0000_4433, 2);

    // Illegal funct3.
    issue(1'b1, 3'd3, 32'h100, 32'd0, 1'b1, 32'd0, 1);
    issue(1'b1, 3'd6, 32'h100, 32'd0, 1'b1, 32'd0, 1);
    issue(1'b0, 3'd3, 32'h100, 32'h1234_5678, 1'b1, 32'd0, 1);
    chk("illegal_st_mask", 64'(acc_mask), 64'd0);
    issue(1'b1, F3_W, 32'h100, 32'd0, 1'b0, 32'h80FF_0000, 1);

    // Reset while in ST_HI: beat0 stays, beat1 never issued.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_funct3 = F3_W;
    req_addr = 32'h30A; req_wdata = 32'hCAFE_F00D;
    #1 chk("rst_st_mask0", 64'(mem_wmask), 64'b1100);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_st_in_sthi", 64'(dbg_state), 64'(S_ST_HI));
    reset = 1'b1;
    #1;
    chk("rst_st_mask1", 64'(mem_wmask), 64'd0);
    chk("rst_st_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_st_idle", 64'(dbg_state), 64'(S_IDLE));
    chk("rst_st_no_resp", 64'(resp_valid), 64'd0);
    issue(1'b1, F3_W, 32'h308, 32'd0, 1'b0, 32'hF00D_0000, 1);
    issue(1'b1, F3_W, 32'h30C, 32'd0, 1'b0, 32'h0000_0000, 1);

    // Reset while a load is waiting: no response.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = F3_W; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_ld_no_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ld_idle", 64'(dbg_state), 64'(S_IDLE));

    // Random aligned word store / byte reload pairs.
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 63) * 4;
      o = $urandom_range(0, 3);
      d = $urandom;
      issue(1'b0, F3_W, 32'(w), d, 1'b0, 32'd0, 1);
      issue(1'b1, F3_W, 32'(w), 32'd0, 1'b0, d, 1);
      issue(1'b1, F3_BU, 32'(w + o), 32'd0, 1'b0, {24'd0, d[8*o +: 8]}, 1);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
